// File: rtl/kmkz_defs.sv
// Shared definitions for the Kamikaze-uRV machine-mode CSR unit:
// CSR addresses, funct3 operation encoding and read-only ID values.
package kmkz_defs;

    localparam logic [11:0] CSR_CYCLE           = 12'hC00;
    localparam logic [11:0] CSR_TIME            = 12'hC01;
    localparam logic [11:0] CSR_INSTRET         = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH          = 12'hC80;
    localparam logic [11:0] CSR_TIMEH           = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH        = 12'hC82;

    localparam logic [11:0] CSR_MCYCLE          = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET        = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH         = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH       = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT   = 12'h320;

    localparam logic [11:0] CSR_MSTATUS         = 12'h300;
    localparam logic [11:0] CSR_MISA            = 12'h301;
    localparam logic [11:0] CSR_MIE             = 12'h304;
    localparam logic [11:0] CSR_MTVEC           = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH        = 12'h340;
    localparam logic [11:0] CSR_MEPC            = 12'h341;
    localparam logic [11:0] CSR_MCAUSE          = 12'h342;
    localparam logic [11:0] CSR_MIP             = 12'h344;

    localparam logic [11:0] CSR_MVENDORID       = 12'hF11;
    localparam logic [11:0] CSR_MARCHID         = 12'hF12;
    localparam logic [11:0] CSR_MIMPID          = 12'hF13;

    // Extra scratch registers (bank index 1 and up) start here.
    localparam logic [11:0] CUSTOM_SCRATCH_BASE = 12'h7C0;

    localparam logic [31:0] ID_MVENDORID        = 32'h414e4c47;
    localparam logic [31:0] ID_MARCHID          = 32'h4b4d4b5a;
    localparam logic [31:0] ID_MIMPID           = 32'h5a483031;
    localparam logic [31:0] ID_MISA             = 32'h60001104;

    // funct3[1:0] selects the operation, funct3[2] selects the immediate source.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int CSR_FUN_IMM_BIT = 2;

endpackage

// File: rtl/kmkz_csr_counter.sv
// CNT_W-bit event counter with inhibit and independent 32-bit low/high
// half write ports; a half write takes priority over the increment.
module kmkz_csr_counter
    import kmkz_defs::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/kmkz_csr_file.sv
// Machine-mode CSR unit: internal cycle/instret counters, count inhibit,
// scratch bank, mtvec with vectored trap targets and illegal-access detection.
module kmkz_csr_file
    import kmkz_defs::*;
#(
    parameter int CNT_W       = 64,
    parameter int N_SCRATCH   = 1,
    parameter int VECTORED_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_is_csr_i,
    input  logic [2:0]  d_fun_i,
    input  logic [4:0]  d_csr_imm_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] d_rs1_i,
    input  logic        instr_retired_i,
    input  logic [39:0] csr_time_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mip_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mcause_i,
    input  logic [31:0] startup_address,
    input  logic        trap_is_irq_i,
    input  logic [4:0]  trap_cause_i,
    output logic [31:0] x_rd_o,
    output logic [31:0] x_csr_write_value_o,
    output logic        x_illegal_o,
    output logic [31:0] vector_base_o,
    output logic [31:0] trap_vec_o
);

    csr_op_e          op;
    logic [31:0]      in2;
    logic [31:0]      rd_raw;
    logic [31:0]      scr_rd;
    logic [31:0]      mtvec_val;
    logic [31:0]      trap_base;
    logic             hit;
    logic             scr_hit;
    logic [1:0]       scr_idx;
    logic             write_intent;
    logic             illegal;
    logic             fire;
    logic             wr_en;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic [63:0]      mcycle_ext;
    logic [63:0]      minstret_ext;

    logic [29:0]      mtvec_base_q;
    logic [29:0]      mtvec_base_d;
    logic             mtvec_mode_q;
    logic             mtvec_mode_d;
    logic [1:0]       cnt_inh_q;
    logic [1:0]       cnt_inh_d;
    logic [31:0]      scratch_q [N_SCRATCH];
    logic [31:0]      scratch_d [N_SCRATCH];

    logic             unused_startup_bits;

    assign unused_startup_bits = ^startup_address[1:0];

    assign fire         = d_is_csr_i && !x_stall_i && !x_kill_i;
    assign op           = csr_op_e'(d_fun_i[1:0]);
    assign in2          = d_fun_i[CSR_FUN_IMM_BIT] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    // Set/clear forms with a zero rs1/uimm field are pure reads.
    assign write_intent = (op == CSR_OP_RW) ||
                          ((op != CSR_OP_NONE) && (d_csr_imm_i != 5'd0));

    assign mcycle_ext   = 64'(mcycle);
    assign minstret_ext = 64'(minstret);
    assign mtvec_val    = {mtvec_base_q, 1'b0, mtvec_mode_q};

    always_comb begin
        scr_hit = 1'b0;
        scr_idx = 2'd0;
        if (d_csr_sel_i == CSR_MSCRATCH) begin
            scr_hit = 1'b1;
        end
        for (int k = 1; k < N_SCRATCH; k++) begin
            if (d_csr_sel_i == CUSTOM_SCRATCH_BASE + 12'(k - 1)) begin
                scr_hit = 1'b1;
                scr_idx = 2'(k);
            end
        end
    end

    always_comb begin
        scr_rd = '0;
        for (int k = 0; k < N_SCRATCH; k++) begin
            if (scr_idx == 2'(k)) begin
                scr_rd = scratch_q[k];
            end
        end
    end

    always_comb begin
        hit    = 1'b1;
        rd_raw = '0;
        case (d_csr_sel_i)
            CSR_CYCLE, CSR_MCYCLE:         rd_raw = mcycle_ext[31:0];
            CSR_CYCLEH, CSR_MCYCLEH:       rd_raw = mcycle_ext[63:32];
            CSR_INSTRET, CSR_MINSTRET:     rd_raw = minstret_ext[31:0];
            CSR_INSTRETH, CSR_MINSTRETH:   rd_raw = minstret_ext[63:32];
            CSR_TIME:                      rd_raw = csr_time_i[31:0];
            CSR_TIMEH:                     rd_raw = {24'h0, csr_time_i[39:32]};
            CSR_MCOUNTINHIBIT:             rd_raw = {29'b0, cnt_inh_q[1], 1'b0, cnt_inh_q[0]};
            CSR_MTVEC:                     rd_raw = mtvec_val;
            CSR_MVENDORID:                 rd_raw = ID_MVENDORID;
            CSR_MARCHID:                   rd_raw = ID_MARCHID;
            CSR_MIMPID:                    rd_raw = ID_MIMPID;
            CSR_MISA:                      rd_raw = ID_MISA;
            CSR_MSTATUS:                   rd_raw = csr_mstatus_i;
            CSR_MIP:                       rd_raw = csr_mip_i;
            CSR_MIE:                       rd_raw = csr_mie_i;
            CSR_MEPC:                      rd_raw = csr_mepc_i;
            CSR_MCAUSE:                    rd_raw = csr_mcause_i;
            default: begin
                hit    = scr_hit;
                rd_raw = scr_hit ? scr_rd : 32'h0;
            end
        endcase
    end

    always_comb begin
        case (op)
            CSR_OP_RW: x_csr_write_value_o = in2;
            CSR_OP_RS: x_csr_write_value_o = rd_raw | in2;
            CSR_OP_RC: x_csr_write_value_o = rd_raw & ~in2;
            default:   x_csr_write_value_o = rd_raw;
        endcase
    end

    // Writing into the 0xC00-0xFFF space is illegal even for mapped addresses.
    assign illegal     = !hit || (write_intent && (d_csr_sel_i[11:10] == 2'b11));
    assign x_illegal_o = d_is_csr_i && illegal;
    assign x_rd_o      = x_illegal_o ? 32'h0 : rd_raw;
    assign wr_en       = fire && !illegal && write_intent;

    kmkz_csr_counter #(
        .CNT_W (CNT_W)
    ) u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (1'b1),
        .inhibit_i (cnt_inh_q[0]),
        .wr_lo_i   (wr_en && (d_csr_sel_i == CSR_MCYCLE)),
        .wr_hi_i   (wr_en && (d_csr_sel_i == CSR_MCYCLEH)),
        .wdata_i   (x_csr_write_value_o),
        .cnt_o     (mcycle)
    );

    kmkz_csr_counter #(
        .CNT_W (CNT_W)
    ) u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (instr_retired_i),
        .inhibit_i (cnt_inh_q[1]),
        .wr_lo_i   (wr_en && (d_csr_sel_i == CSR_MINSTRET)),
        .wr_hi_i   (wr_en && (d_csr_sel_i == CSR_MINSTRETH)),
        .wdata_i   (x_csr_write_value_o),
        .cnt_o     (minstret)
    );

    always_comb begin
        cnt_inh_d    = cnt_inh_q;
        mtvec_base_d = mtvec_base_q;
        mtvec_mode_d = mtvec_mode_q;
        if (wr_en && (d_csr_sel_i == CSR_MCOUNTINHIBIT)) begin
            cnt_inh_d = {x_csr_write_value_o[2], x_csr_write_value_o[0]};
        end
        if (wr_en && (d_csr_sel_i == CSR_MTVEC)) begin
            mtvec_base_d = x_csr_write_value_o[31:2];
            mtvec_mode_d = (VECTORED_EN != 0) ? x_csr_write_value_o[0] : 1'b0;
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        for (int k = 0; k < N_SCRATCH; k++) begin
            if (wr_en && scr_hit && (scr_idx == 2'(k))) begin
                scratch_d[k] = x_csr_write_value_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_inh_q    <= 2'b00;
            mtvec_base_q <= startup_address[31:2];
            mtvec_mode_q <= 1'b0;
            for (int k = 0; k < N_SCRATCH; k++) begin
                scratch_q[k] <= '0;
            end
        end else begin
            cnt_inh_q    <= cnt_inh_d;
            mtvec_base_q <= mtvec_base_d;
            mtvec_mode_q <= mtvec_mode_d;
            scratch_q    <= scratch_d;
        end
    end

    // Vectored mode only redirects interrupts; exceptions use the base.
    assign trap_base     = {mtvec_base_q, 2'b00};
    assign trap_vec_o    = (mtvec_mode_q && trap_is_irq_i) ?
                           trap_base + {25'b0, trap_cause_i, 2'b00} : trap_base;
    assign vector_base_o = mtvec_val;

endmodule

// File: tb/tb_kmkz_csr_file.sv
// Self-checking bench for kmkz_csr_file: two parameterisations share the same
// stimulus and are compared against an arithmetic model of the CSR map.
module tb_kmkz_csr_file;

    localparam int          CW    = 40;
    localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        x_stall_i, x_kill_i, d_is_csr_i, instr_retired_i;
    logic [2:0]  d_fun_i;
    logic [4:0]  d_csr_imm_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] d_rs1_i;
    logic [39:0] csr_time_i;
    logic [31:0] csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i;
    logic [31:0] startup_address;
    logic        trap_is_irq_i;
    logic [4:0]  trap_cause_i;

    logic [31:0] rd_a, wv_a, vbase_a, tvec_a;
    logic        ill_a;
    logic [31:0] rd_b, wv_b, vbase_b, tvec_b;
    logic        ill_b;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_cyc, m_ins;
    logic        m_inh0, m_inh2;
    logic [31:0] m_mtvec_a, m_mtvec_b;
    logic [31:0] m_scr [4];

    logic [31:0] last_rd_a, last_wv_a, last_tvec_a, last_tvec_b;
    logic        last_ill_a, last_ill_b;

    kmkz_csr_file #(.CNT_W(CW), .N_SCRATCH(2), .VECTORED_EN(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i), .d_csr_imm_i(d_csr_imm_i),
        .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .instr_retired_i(instr_retired_i),
        .csr_time_i(csr_time_i), .csr_mstatus_i(csr_mstatus_i), .csr_mip_i(csr_mip_i),
        .csr_mie_i(csr_mie_i), .csr_mepc_i(csr_mepc_i), .csr_mcause_i(csr_mcause_i),
        .startup_address(startup_address), .trap_is_irq_i(trap_is_irq_i),
        .trap_cause_i(trap_cause_i), .x_rd_o(rd_a), .x_csr_write_value_o(wv_a),
        .x_illegal_o(ill_a), .vector_base_o(vbase_a), .trap_vec_o(tvec_a)
    );

    kmkz_csr_file #(.CNT_W(64), .N_SCRATCH(1), .VECTORED_EN(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i), .d_csr_imm_i(d_csr_imm_i),
        .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .instr_retired_i(instr_retired_i),
        .csr_time_i(csr_time_i), .csr_mstatus_i(csr_mstatus_i), .csr_mip_i(csr_mip_i),
        .csr_mie_i(csr_mie_i), .csr_mepc_i(csr_mepc_i), .csr_mcause_i(csr_mcause_i),
        .startup_address(startup_address), .trap_is_irq_i(trap_is_irq_i),
        .trap_cause_i(trap_cause_i), .x_rd_o(rd_b), .x_csr_write_value_o(wv_b),
        .x_illegal_o(ill_b), .vector_base_o(vbase_b), .trap_vec_o(tvec_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc     = 64'h0;
        m_ins     = 64'h0;
        m_inh0    = 1'b0;
        m_inh2    = 1'b0;
        m_mtvec_a = {startup_address[31:2], 2'b00};
        m_mtvec_b = {startup_address[31:2], 2'b00};
        for (int k = 0; k < 4; k++) m_scr[k] = 32'h0;
    endtask

    // Returns {mapped, raw read value} for an address in a unit with nscr scratch registers.
    function automatic logic [32:0] model_read(input logic [11:0] a, input int nscr, input logic [31:0] mtvec);
        logic [32:0] r;
        r = {1'b1, 32'h0};
        case (a)
            12'hC00, 12'hB00: r[31:0] = m_cyc[31:0];
            12'hC80, 12'hB80: r[31:0] = m_cyc[63:32];
            12'hC02, 12'hB02: r[31:0] = m_ins[31:0];
            12'hC82, 12'hB82: r[31:0] = m_ins[63:32];
            12'hC01:          r[31:0] = csr_time_i[31:0];
            12'hC81:          r[31:0] = {24'h0, csr_time_i[39:32]};
            12'h320:          r[31:0] = {29'b0, m_inh2, 1'b0, m_inh0};
            12'h305:          r[31:0] = mtvec;
            12'hF11:          r[31:0] = 32'h414e4c47;
            12'hF12:          r[31:0] = 32'h4b4d4b5a;
            12'hF13:          r[31:0] = 32'h5a483031;
            12'h301:          r[31:0] = 32'h60001104;
            12'h300:          r[31:0] = csr_mstatus_i;
            12'h344:          r[31:0] = csr_mip_i;
            12'h304:          r[31:0] = csr_mie_i;
            12'h341:          r[31:0] = csr_mepc_i;
            12'h342:          r[31:0] = csr_mcause_i;
            12'h340:          r[31:0] = m_scr[0];
            default: begin
                if (int'(a) >= 'h7C0 && int'(a) < 'h7C0 + nscr - 1)
                    r[31:0] = m_scr[int'(a) - 'h7C0 + 1];
                else
                    r = 33'h0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old, input logic [31:0] in2);
        if (op == 2'b01) return in2;
        if (op == 2'b10) return old | in2;
        return old & ~in2;
    endfunction

    function automatic logic write_intent();
        return (d_fun_i[1:0] == 2'b01) || (d_csr_imm_i != 5'd0);
    endfunction

    function automatic logic [31:0] operand();
        return d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    endfunction

    function automatic logic [31:0] trap_target(input logic [31:0] mtvec);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[0] && trap_is_irq_i) return base + 32'(trap_cause_i) * 32'd4;
        return base;
    endfunction

    task automatic model_update();
        logic [32:0] ra, rb;
        logic [31:0] wva, wvb;
        logic        intent, fire, do_a, do_b, cw, iw;
        intent = write_intent();
        fire   = d_is_csr_i && !x_stall_i && !x_kill_i;
        ra     = model_read(d_csr_sel_i, 2, m_mtvec_a);
        rb     = model_read(d_csr_sel_i, 1, m_mtvec_b);
        wva    = apply_op(d_fun_i[1:0], ra[31:0], operand());
        wvb    = apply_op(d_fun_i[1:0], rb[31:0], operand());
        do_a   = fire && intent && ra[32] && (d_csr_sel_i[11:10] != 2'b11);
        do_b   = fire && intent && rb[32] && (d_csr_sel_i[11:10] != 2'b11);
        cw     = do_a && (d_csr_sel_i == 12'hB00 || d_csr_sel_i == 12'hB80);
        iw     = do_a && (d_csr_sel_i == 12'hB02 || d_csr_sel_i == 12'hB82);
        if (do_a && d_csr_sel_i == 12'hB00) m_cyc = {m_cyc[63:32], wva};
        if (do_a && d_csr_sel_i == 12'hB80) m_cyc = ({wva, 32'h0} | {32'h0, m_cyc[31:0]}) & CMASK;
        if (do_a && d_csr_sel_i == 12'hB02) m_ins = {m_ins[63:32], wva};
        if (do_a && d_csr_sel_i == 12'hB82) m_ins = ({wva, 32'h0} | {32'h0, m_ins[31:0]}) & CMASK;
        if (!cw && !m_inh0) m_cyc = (m_cyc + 64'd1) & CMASK;
        if (!iw && !m_inh2 && instr_retired_i) m_ins = (m_ins + 64'd1) & CMASK;
        if (do_a && d_csr_sel_i == 12'h320) begin
            m_inh0 = wva[0];
            m_inh2 = wva[2];
        end
        if (do_a && d_csr_sel_i == 12'h305) m_mtvec_a = {wva[31:2], 1'b0, wva[0]};
        if (do_b && d_csr_sel_i == 12'h305) m_mtvec_b = {wvb[31:2], 2'b00};
        if (do_a && d_csr_sel_i == 12'h340) m_scr[0] = wva;
        if (do_a && d_csr_sel_i == 12'h7C0) m_scr[1] = wva;
    endtask

    task automatic apply_stimulus(input logic is_csr, input logic [2:0] fun, input logic [4:0] imm,
                                  input logic [11:0] sel, input logic [31:0] rs1,
                                  input logic stall, input logic kill, input logic retired);
        d_is_csr_i      = is_csr;
        d_fun_i         = fun;
        d_csr_imm_i     = imm;
        d_csr_sel_i     = sel;
        d_rs1_i         = rs1;
        x_stall_i       = stall;
        x_kill_i        = kill;
        instr_retired_i = retired;
    endtask

    // Called one time unit after a rising edge; checks before the next edge, then advances the model.
    task automatic step(input string tag);
        logic [32:0] ra, rb;
        logic        intent, leg_a, leg_b, e_ill_a, e_ill_b;
        logic [31:0] e_rd_a, e_wv_a;
        intent  = write_intent();
        ra      = model_read(d_csr_sel_i, 2, m_mtvec_a);
        rb      = model_read(d_csr_sel_i, 1, m_mtvec_b);
        leg_a   = ra[32] && !(intent && d_csr_sel_i[11:10] == 2'b11);
        leg_b   = rb[32] && !(intent && d_csr_sel_i[11:10] == 2'b11);
        e_ill_a = d_is_csr_i && !leg_a;
        e_ill_b = d_is_csr_i && !leg_b;
        e_rd_a  = e_ill_a ? 32'h0 : ra[31:0];
        e_wv_a  = apply_op(d_fun_i[1:0], ra[31:0], operand());
        #3;
        check_output({tag, ".rd"}, rd_a, e_rd_a);
        check_output({tag, ".ill_a"}, {31'b0, ill_a}, {31'b0, e_ill_a});
        check_output({tag, ".ill_b"}, {31'b0, ill_b}, {31'b0, e_ill_b});
        if (d_is_csr_i && leg_a) check_output({tag, ".wval"}, wv_a, e_wv_a);
        check_output({tag, ".vbase_a"}, vbase_a, m_mtvec_a);
        check_output({tag, ".vbase_b"}, vbase_b, m_mtvec_b);
        check_output({tag, ".tvec_a"}, tvec_a, trap_target(m_mtvec_a));
        check_output({tag, ".tvec_b"}, tvec_b, trap_target(m_mtvec_b));
        last_rd_a   = rd_a;
        last_wv_a   = wv_a;
        last_ill_a  = ill_a;
        last_ill_b  = ill_b;
        last_tvec_a = tvec_a;
        last_tvec_b = tvec_b;
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    logic [11:0] addr_tab [26] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                   12'hC02, 12'hC82, 12'hC01, 12'hC81, 12'h320, 12'h305,
                                   12'h340, 12'h7C0, 12'h7C1, 12'hF11, 12'hF12, 12'hF13,
                                   12'h301, 12'h300, 12'h344, 12'h304, 12'h341, 12'h342,
                                   12'h7FF, 12'h123};
    logic [2:0]  fun_tab [6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        startup_address = 32'h0000_1003;
        csr_time_i      = 40'h12_3456_789A;
        csr_mstatus_i   = 32'h0000_1888;
        csr_mip_i       = 32'h0000_0080;
        csr_mie_i       = 32'h0000_0888;
        csr_mepc_i      = 32'h0000_4444;
        csr_mcause_i    = 32'h8000_0007;
        trap_is_irq_i   = 1'b0;
        trap_cause_i    = 5'd0;
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0);

        #1 rst_i = 1'b0;
        model_reset();
        #2;
        check_output("reset.mcycle", rd_a, 32'h0);
        check_output("reset.mtvec", vbase_a, 32'h0000_1000);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        apply_stimulus(1'b0, 3'b010, 5'd0, 12'h305, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_mtvec");
        check_output("mtvec_reset_read", last_rd_a, 32'h0000_1000);
        for (int i = 1; i < 10; i++) step("idle");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_cycle");
        check_output("mcycle_after_10", last_rd_a, 32'd10);

        apply_stimulus(1'b1, 3'b001, 5'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step("wr_cycle_lo");
        check_output("wr_cycle_lo.wval", last_wv_a, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_cycle_lo");
        check_output("cycle_lo_written", last_rd_a, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB80, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_cycle_hi");
        check_output("cycle_hi_carry", last_rd_a, 32'd1);

        apply_stimulus(1'b1, 3'b001, 5'd1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step("wr_cycle_hi");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB80, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_cycle_hi2");
        check_output("cycle_hi_truncated", last_rd_a, 32'h0000_00FF);
        apply_stimulus(1'b1, 3'b001, 5'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step("wr_cycle_lo2");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB80, 32'h0, 1'b0, 1'b0, 1'b0);
        step("wrap_pre");
        check_output("cycle_hi_before_wrap", last_rd_a, 32'h0000_00FF);
        step("wrap_post");
        check_output("cycle_hi_after_wrap", last_rd_a, 32'h0);

        apply_stimulus(1'b1, 3'b001, 5'd1, 12'hB02, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        step("wr_instret");
        apply_stimulus(1'b1, 3'b110, 5'd5, 12'h320, 32'h0, 1'b0, 1'b0, 1'b0);
        step("inhibit_set");
        apply_stimulus(1'b1, 3'b001, 5'd1, 12'hB00, 32'h0000_0050, 1'b0, 1'b0, 1'b1);
        step("wr_cycle_frozen");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB02, 32'h0, 1'b0, 1'b0, 1'b1);
        step("frozen_ins1");
        check_output("instret_frozen1", last_rd_a, 32'h0000_0100);
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b1);
        step("frozen_cyc");
        check_output("cycle_frozen", last_rd_a, 32'h0000_0050);
        apply_stimulus(1'b1, 3'b111, 5'd1, 12'h320, 32'h0, 1'b0, 1'b0, 1'b1);
        step("inhibit_clr0");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b1);
        step("resume1");
        check_output("cycle_resume1", last_rd_a, 32'h0000_0050);
        step("resume2");
        check_output("cycle_resume2", last_rd_a, 32'h0000_0051);
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB02, 32'h0, 1'b0, 1'b0, 1'b1);
        step("frozen_ins2");
        check_output("instret_frozen2", last_rd_a, 32'h0000_0100);
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'h320, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_inhibit");
        check_output("inhibit_value", last_rd_a, 32'h4);
        apply_stimulus(1'b1, 3'b111, 5'd4, 12'h320, 32'h0, 1'b0, 1'b0, 1'b0);
        step("inhibit_clr2");

        apply_stimulus(1'b1, 3'b010, 5'd0, 12'hC00, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rs_cycle_noop");
        check_output("ro_read_legal", {31'b0, last_ill_a}, 32'h0);
        apply_stimulus(1'b1, 3'b010, 5'd3, 12'hC00, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rs_cycle_wr");
        check_output("ro_write_illegal", {31'b0, last_ill_a}, 32'h1);
        check_output("ro_write_rd_zero", last_rd_a, 32'h0);
        apply_stimulus(1'b1, 3'b010, 5'd0, 12'h7FF, 32'h0, 1'b0, 1'b0, 1'b0);
        step("rd_unmapped");
        check_output("unmapped_illegal", {31'b0, last_ill_a}, 32'h1);
        check_output("unmapped_rd_zero", last_rd_a, 32'h0);

        apply_stimulus(1'b1, 3'b001, 5'd1, 12'h305, 32'h0000_2001, 1'b0, 1'b0, 1'b0);
        step("wr_mtvec");
        apply_stimulus(1'b0, 3'b010, 5'd0, 12'h305, 32'h0, 1'b0, 1'b0, 1'b0);
        trap_is_irq_i = 1'b1;
        trap_cause_i  = 5'd7;
        step("trap_irq");
        check_output("tvec_vectored_irq", last_tvec_a, 32'h0000_201C);
        check_output("tvec_novector_irq", last_tvec_b, 32'h0000_2000);
        trap_is_irq_i = 1'b0;
        step("trap_exc");
        check_output("tvec_vectored_exc", last_tvec_a, 32'h0000_2000);

        apply_stimulus(1'b1, 3'b001, 5'd1, 12'h7C0, 32'hA5A5_1234, 1'b1, 1'b0, 1'b0);
        step("scr_stalled");
        check_output("scr1_illegal_n1", {31'b0, last_ill_b}, 32'h1);
        apply_stimulus(1'b1, 3'b010, 5'd0, 12'h7C0, 32'h0, 1'b0, 1'b0, 1'b0);
        step("scr_rd0");
        check_output("scr_stall_nochange", last_rd_a, 32'h0);
        apply_stimulus(1'b1, 3'b001, 5'd1, 12'h340, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
        step("mscr_killed");
        apply_stimulus(1'b1, 3'b001, 5'd1, 12'h7C0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0);
        step("scr_fire");
        apply_stimulus(1'b1, 3'b010, 5'd0, 12'h7C0, 32'h0, 1'b0, 1'b0, 1'b0);
        step("scr_rd1");
        check_output("scr_readback", last_rd_a, 32'hA5A5_1234);
        apply_stimulus(1'b1, 3'b010, 5'd0, 12'h340, 32'h0, 1'b0, 1'b0, 1'b0);
        step("mscr_rd");
        check_output("mscr_kill_nochange", last_rd_a, 32'h0);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 4) != 0, fun_tab[$urandom_range(0, 5)],
                           ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom),
                           addr_tab[$urandom_range(0, 25)], $urandom,
                           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                           $urandom_range(0, 1) != 0);
            csr_time_i    = {8'($urandom), 32'($urandom)};
            csr_mstatus_i = $urandom;
            csr_mip_i     = $urandom;
            csr_mie_i     = $urandom;
            csr_mepc_i    = $urandom;
            csr_mcause_i  = $urandom;
            trap_is_irq_i = $urandom_range(0, 1) != 0;
            trap_cause_i  = 5'($urandom);
            step("rand");
        end

        apply_stimulus(1'b0, 3'b010, 5'd0, 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0);
        startup_address = 32'h0000_4007;
        #1 rst_i = 1'b0;
        #1;
        check_output("midreset.mcycle", rd_a, 32'h0);
        check_output("midreset.mtvec", vbase_a, 32'h0000_4004);
        #1 rst_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        model_update();
        #1;
        step("post_reset");
        check_output("post_reset_count", last_rd_a, 32'd1);
        for (int i = 0; i < 5; i++) step("post_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
